// File: rtl/arbitro_banco_reg.sv
// arbitro_banco_reg: round-robin arbiter for the single write port of the 4x32 register bank
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_valido_a/b, i_id_a/b, i_dado_a/b  requester A/B write requests (held stable while valid)
//   o_pronto_a/b                    combinational grant, transfer at the rising edge where valid & pronto
//   i_trava                         blocks new grants while idle
//   i_fonte_ext1                    datapath read-1 select, forwarded except while verifying
//   i_dado_lido1                    bank read-port-1 data, used only by write-verify
//   o_id_reg, o_escrita, o_dado     bank write index / enable / data
//   o_fonte1                        bank read-1 select
//   o_ocupado, o_erro, o_conta_escritas  busy, sticky verify mismatch, completed-write counter
// Macro ARBITRO_CONFERE_EN enables the two-cycle read-back verify after each write.
module arbitro_banco_reg #(
    parameter int LARGURA_DADO  = 32,
    parameter int LARGURA_ID    = 2,
    parameter int LARGURA_CONTA = 16
)(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valido_a,
    input  logic                     i_valido_b,
    input  logic [LARGURA_ID-1:0]    i_id_a,
    input  logic [LARGURA_ID-1:0]    i_id_b,
    input  logic [LARGURA_DADO-1:0]  i_dado_a,
    input  logic [LARGURA_DADO-1:0]  i_dado_b,
    output logic                     o_pronto_a,
    output logic                     o_pronto_b,
    input  logic                     i_trava,
    input  logic [LARGURA_ID-1:0]    i_fonte_ext1,
    input  logic [LARGURA_DADO-1:0]  i_dado_lido1,
    output logic [LARGURA_ID-1:0]    o_id_reg,
    output logic                     o_escrita,
    output logic [LARGURA_DADO-1:0]  o_dado,
    output logic [LARGURA_ID-1:0]    o_fonte1,
    output logic                     o_ocupado,
    output logic                     o_erro,
    output logic [LARGURA_CONTA-1:0] o_conta_escritas
);
    typedef enum logic [1:0] {OCIOSO, GRAVA, CONFERE} estado_t;
    estado_t                  r_estado;
    logic                     r_ptr;
    logic [LARGURA_ID-1:0]    r_id;
    logic [LARGURA_DADO-1:0]  r_dado;
    logic                     r_escrita;
    logic [LARGURA_CONTA-1:0] r_conta;
    logic                     w_livre;
    logic                     w_ganha_a;
    logic                     w_ganha_b;
    // r_ptr=0 favours A on a tie, r_ptr=1 favours B
    assign w_livre   = r_estado == OCIOSO && !i_trava;
    assign w_ganha_a = w_livre && i_valido_a && (!i_valido_b || !r_ptr);
    assign w_ganha_b = w_livre && i_valido_b && (!i_valido_a || r_ptr);
    // grants are forced low while reset is asserted; flops use the ungated terms
    assign o_pronto_a       = i_rst_n && w_ganha_a;
    assign o_pronto_b       = i_rst_n && w_ganha_b;
    assign o_id_reg         = r_id;
    assign o_dado           = r_dado;
    assign o_escrita        = r_escrita;
    assign o_ocupado        = r_estado != OCIOSO;
    assign o_conta_escritas = r_conta;
`ifdef ARBITRO_CONFERE_EN
    logic r_fase;
    logic r_erro;
    assign o_fonte1 = r_estado == CONFERE ? r_id : i_fonte_ext1;
    assign o_erro   = r_erro;
`else
    logic w_unused;
    assign w_unused = ^i_dado_lido1;
    assign o_fonte1 = i_fonte_ext1;
    assign o_erro   = 1'b0;
`endif
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_estado  <= OCIOSO;
            r_ptr     <= 1'b0;
            r_id      <= '0;
            r_dado    <= '0;
            r_escrita <= 1'b0;
            r_conta   <= '0;
`ifdef ARBITRO_CONFERE_EN
            r_fase    <= 1'b0;
            r_erro    <= 1'b0;
`endif
        end else begin
            case (r_estado)
                OCIOSO: if (w_ganha_a || w_ganha_b) begin
                    r_id      <= w_ganha_a ? i_id_a : i_id_b;
                    r_dado    <= w_ganha_a ? i_dado_a : i_dado_b;
                    r_escrita <= 1'b1;
                    r_ptr     <= w_ganha_a;
                    r_estado  <= GRAVA;
                end
                GRAVA: begin
                    r_escrita <= 1'b0;
                    r_conta   <= r_conta + LARGURA_CONTA'(1);
`ifdef ARBITRO_CONFERE_EN
                    r_fase    <= 1'b0;
                    r_estado  <= CONFERE;
`else
                    r_estado  <= OCIOSO;
`endif
                end
`ifdef ARBITRO_CONFERE_EN
                // bank read data is compared only at the end of the second verify cycle
                CONFERE: begin
                    r_fase <= !r_fase;
                    if (r_fase) begin
                        if (i_dado_lido1 != r_dado)
                            r_erro <= 1'b1;
                        r_estado <= OCIOSO;
                    end
                end
`endif
                default: r_estado <= OCIOSO;
            endcase
        end
    end
endmodule
